i2s_tx_sched: RTL and testbench

- Stereo sample scheduler between the equalizer output stream and the I2S serializer.
- Buffers left/right frames in a small FIFO.
- Starts and stops the serializer on frame boundaries.
- Presents the correct channel word on each serializer word request; mutes on underrun and counts underruns.
- Sits after the filter bank, directly driving the serializer's data_in/enable.

---
 rtl/i2s_tx_sched.sv | 180 ++++++++++++++++++
 tb/tb_i2s_tx_sched.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_sched.sv
// Stereo frame scheduler feeding an I2S serializer: frame FIFO, start/stop on frame boundaries,
// mute and count on underrun. Define I2S_SCHED_REPEAT_EN to resend the last popped frame instead.
module i2s_tx_sched #(
  parameter int          FIFO_DEPTH  = 4,
  parameter int          PRIME_LEVEL = 2,
  parameter logic [15:0] MUTE_WORD   = 16'h0000
) (
  input  logic                          clk_in,
  input  logic                          rstn,
  input  logic                          ctrl_en,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [15:0]                   s_left,
  input  logic [15:0]                   s_right,
  input  logic                          tx_req,
  input  logic                          tx_ws,
  output logic                          tx_enable,
  output logic [15:0]                   tx_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic [15:0]                   underrun_cnt
);

  // state | meaning
  // IDLE  | serializer disabled; wait for ctrl_en and PRIME_LEVEL frames
  // PRIME | pop the first frame: left into tx_data, right into the hold register
  // RUN   | serve word requests; pop, mute or stop at each frame boundary
  // STOP  | boundary seen with ctrl_en low; drop enable and return to IDLE
  typedef enum logic [1:0] {IDLE, PRIME, RUN, STOP} state_t;

  localparam int               PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   FULL_LVL  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   PRIME_LVL = (PTR_W+1)'(PRIME_LEVEL);

  state_t            state_q, state_d;
  logic [15:0]       mem_l_q [FIFO_DEPTH];
  logic [15:0]       mem_r_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    level_q, level_d;
  logic [15:0]       tx_data_q, tx_data_d;
  logic [15:0]       hold_q, hold_d;
  logic              tx_en_q, tx_en_d;
  logic              underrun_q;
  logic [15:0]       und_cnt_q;
  logic              ctrl_en_q;
  logic              push, pop, und_set, ctrl_rise;
  logic [15:0]       head_l, head_r, fill_l, fill_r;

  assign s_ready   = (level_q != FULL_LVL);
  assign push      = s_valid && s_ready;
  assign head_l    = mem_l_q[rd_ptr_q];
  assign head_r    = mem_r_q[rd_ptr_q];
  assign ctrl_rise = ctrl_en && !ctrl_en_q;

`ifdef I2S_SCHED_REPEAT_EN
  logic [15:0] last_l_q, last_r_q;

  // Seeded with MUTE_WORD so an underrun before the first pop still sends silence.
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      last_l_q <= MUTE_WORD;
      last_r_q <= MUTE_WORD;
    end else if (pop) begin
      last_l_q <= head_l;
      last_r_q <= head_r;
    end
  end

  assign fill_l = last_l_q;
  assign fill_r = last_r_q;
`else
  assign fill_l = MUTE_WORD;
  assign fill_r = MUTE_WORD;
`endif

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    hold_d    = hold_q;
    tx_en_d   = tx_en_q;
    pop       = 1'b0;
    und_set   = 1'b0;
    case (state_q)
      IDLE: begin
        tx_en_d = 1'b0;
        if (ctrl_en && (level_q >= PRIME_LVL)) state_d = PRIME;
      end
      PRIME: begin
        pop       = 1'b1;
        tx_data_d = head_l;
        hold_d    = head_r;
        tx_en_d   = 1'b1;
        state_d   = RUN;
      end
      RUN: begin
        if (tx_req) begin
          if (tx_ws) begin
            tx_data_d = hold_q;
          end else if (!ctrl_en) begin
            state_d = STOP;
          end else if (level_q != '0) begin
            pop       = 1'b1;
            tx_data_d = head_l;
            hold_d    = head_r;
          end else begin
            // A push landing in this same cycle waits for the next boundary.
            und_set   = 1'b1;
            tx_data_d = fill_l;
            hold_d    = fill_r;
          end
        end
      end
      STOP: begin
        tx_en_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      tx_data_q  <= '0;
      hold_q     <= '0;
      tx_en_q    <= 1'b0;
      underrun_q <= 1'b0;
      und_cnt_q  <= '0;
      ctrl_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      hold_q    <= hold_d;
      tx_en_q   <= tx_en_d;
      level_q   <= level_d;
      ctrl_en_q <= ctrl_en;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (und_set) begin
        underrun_q <= 1'b1;
      end else if (ctrl_rise) begin
        underrun_q <= 1'b0;
      end
      if (und_set && (und_cnt_q != 16'hFFFF)) begin
        und_cnt_q <= und_cnt_q + 16'd1;
      end
    end
  end

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_l_q[wr_ptr_q] <= s_left;
      mem_r_q[wr_ptr_q] <= s_right;
    end
  end

  assign tx_enable    = tx_en_q;
  assign tx_data      = tx_data_q;
  assign fifo_level   = level_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = und_cnt_q;

endmodule

// File: tb/tb_i2s_tx_sched.sv
// Self-checking bench for i2s_tx_sched with a word-requesting serializer model and a frame-level
// reference model; honours I2S_SCHED_REPEAT_EN when the design is built with it.
module tb_i2s_tx_sched;
  localparam int          W    = 8;          // cycles per serialized word
  localparam logic [15:0] MUTE = 16'h0000;
`ifdef I2S_SCHED_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rstn, ctrl_en, s_valid, s_ready, tx_req, tx_ws, tx_enable, underrun;
  logic [15:0] s_left, s_right, tx_data, underrun_cnt;
  logic [2:0]  fifo_level;

  int          tests = 0;
  int          fails = 0;
  logic [16:0] loads[$];    // {is_left, word} as captured by the serializer
  logic [31:0] pushed[$];   // {left, right} frames accepted upstream
  bit          ser_stall = 1'b0;
  bit          ser_run   = 1'b0;
  int          ph        = 0;
  bit          ch_left   = 1'b1;

  i2s_tx_sched #(.FIFO_DEPTH(4), .PRIME_LEVEL(2), .MUTE_WORD(MUTE)) dut (
    .clk_in(clk_in), .rstn(rstn), .ctrl_en(ctrl_en), .s_valid(s_valid), .s_ready(s_ready),
    .s_left(s_left), .s_right(s_right), .tx_req(tx_req), .tx_ws(tx_ws),
    .tx_enable(tx_enable), .tx_data(tx_data), .fifo_level(fifo_level),
    .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  always #5 clk_in = ~clk_in;

  // Serializer: loads a word every W cycles, pulses tx_req 3 cycles before each load.
  initial begin
    tx_req = 1'b0;
    tx_ws  = 1'b0;
    forever begin
      @(negedge clk_in);
      tx_req = 1'b0;
      if (ser_run && tx_enable !== 1'b1) begin
        ser_run = 1'b0;
        tx_ws   = 1'b0;
      end
      if (!ser_run && tx_enable === 1'b1 && !ser_stall) begin
        ser_run = 1'b1;
        ph      = 0;
        ch_left = 1'b1;
      end
      if (ser_run) begin
        if (ph == 0) begin
          loads.push_back({ch_left, tx_data});
          tx_ws   = ch_left;
          ch_left = !ch_left;
        end
        if (ph == W - 3) tx_req = 1'b1;
        ph = (ph == W - 1) ? 0 : ph + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    ctrl_en = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0; ser_stall = 1'b0;
    @(negedge clk_in);
    rstn = 1'b0;
    repeat (3) @(negedge clk_in);
    rstn = 1'b1;
    @(negedge clk_in);
    loads.delete();
    pushed.delete();
  endtask

  task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
    int t;
    t = 0;
    s_valid = 1'b1; s_left = l; s_right = r;
    while (s_ready !== 1'b1 && t < 2000) begin
      @(negedge clk_in);
      t++;
    end
    if (s_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL push_timeout: s_ready=%b required 1", s_ready);
    end else begin
      pushed.push_back({l, r});
    end
    @(negedge clk_in);
    s_valid = 1'b0;
  endtask

  task automatic wait_loads(input int n, input string name);
    int t;
    t = 0;
    while (loads.size() < n && t < 1000) begin
      @(negedge clk_in);
      t++;
    end
    if (loads.size() < n) begin
      tests++; fails++;
      $display("FAIL %s: timeout, loads=%0d required %0d", name, loads.size(), n);
    end
  endtask

  task automatic wait_stop(input string name);
    int t;
    t = 0;
    while ((tx_enable !== 1'b0 || ser_run) && t < 1000) begin
      @(negedge clk_in);
      t++;
    end
    if (tx_enable !== 1'b0) begin
      tests++; fails++;
      $display("FAIL %s: tx_enable=%b required 0", name, tx_enable);
    end
    repeat (2) @(negedge clk_in);
  endtask

  function automatic logic [31:0] rand_frame();
    logic [31:0] f;
    do f = {16'($urandom_range(1, 65535)), 16'($urandom_range(1, 65535))};
    while (pushed.size() > 0 && f == pushed[pushed.size() - 1]);
    return f;
  endfunction

  // Frame-level model: every played frame is either the next pushed frame, or a fill frame
  // (mute, or a repeat of the previous real frame) sent because nothing was available.
  function automatic void classify(output int n_real, output int n_fill, output int n_bad);
    logic [31:0] last, fr, fill;
    last = {MUTE, MUTE};
    n_real = 0; n_fill = 0; n_bad = 0;
    for (int k = 0; k + 1 < loads.size(); k += 2) begin
      fill = REPEAT_EN ? last : {MUTE, MUTE};
      fr   = {loads[k][15:0], loads[k+1][15:0]};
      if (loads[k][16] !== 1'b1 || loads[k+1][16] !== 1'b0) n_bad++;
      if (n_real < pushed.size() && fr === pushed[n_real]) begin
        n_real++;
        last = fr;
      end else if (fr === fill) begin
        n_fill++;
      end else begin
        n_bad++;
      end
    end
    if (loads.size() % 2 != 0) n_bad++;
  endfunction

  task automatic test_reset();
    do_reset();
    tests++; if (tx_enable !== 1'b0) begin fails++; $display("FAIL reset_tx_enable: got %b required 0", tx_enable); end
    tests++; if (tx_data !== 16'h0) begin fails++; $display("FAIL reset_tx_data: got %h required 0000", tx_data); end
    tests++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL reset_level: got %0d required 0", fifo_level); end
    tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun: got %b required 0", underrun); end
    tests++; if (underrun_cnt !== 16'h0) begin fails++; $display("FAIL reset_cnt: got %0d required 0", underrun_cnt); end
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL reset_s_ready: got %b required 1", s_ready); end
  endtask

  task automatic test_prime_and_stop();
    do_reset();
    ctrl_en = 1'b1; ser_stall = 1'b1;
    push_frame(16'h1234, 16'hABCD);
    repeat (4) @(negedge clk_in);
    tests++; if (tx_enable !== 1'b0) begin fails++; $display("FAIL prime_one_frame_en: got %b required 0", tx_enable); end
    tests++; if (fifo_level !== 3'd1) begin fails++; $display("FAIL prime_one_frame_lvl: got %0d required 1", fifo_level); end
    push_frame(16'h5678, 16'h9ABC);
    @(negedge clk_in);
    tests++; if (tx_enable !== 1'b0) begin fails++; $display("FAIL prime_cycle_en: got %b required 0", tx_enable); end
    @(negedge clk_in);
    tests++; if (tx_enable !== 1'b1) begin fails++; $display("FAIL prime_run_en: got %b required 1", tx_enable); end
    tests++; if (tx_data !== 16'h1234) begin fails++; $display("FAIL prime_run_data: got %h required 1234", tx_data); end
    tests++; if (fifo_level !== 3'd1) begin fails++; $display("FAIL prime_run_lvl: got %0d required 1", fifo_level); end
    ser_stall = 1'b0;
    wait_loads(1, "stop_first_load");
    ctrl_en = 1'b0;
    wait_stop("stop_mid_left");
    tests++; if (loads.size() != 2) begin fails++; $display("FAIL stop_word_count: got %0d required 2", loads.size()); end
    if (loads.size() >= 2) begin
      tests++; if (loads[0] !== {1'b1, 16'h1234}) begin fails++; $display("FAIL stop_left: got %h required 11234", loads[0]); end
      tests++; if (loads[1] !== {1'b0, 16'hABCD}) begin fails++; $display("FAIL stop_right: got %h required 0abcd", loads[1]); end
    end
    tests++; if (fifo_level !== 3'd1) begin fails++; $display("FAIL stop_retained: got %0d required 1", fifo_level); end
  endtask

  task automatic test_stream();
    logic [16:0] exp;
    do_reset();
    ctrl_en = 1'b1;
    for (int n = 0; n < 16; n++) push_frame(16'(n), 16'h8000 | 16'(n));
    wait_loads(31, "stream_loads");
    ctrl_en = 1'b0;
    wait_stop("stream_stop");
    tests++; if (loads.size() != 32) begin fails++; $display("FAIL stream_count: got %0d required 32", loads.size()); end
    for (int k = 0; k < 32 && k < loads.size(); k++) begin
      exp = (k % 2 == 0) ? {1'b1, 16'(k / 2)} : {1'b0, 16'h8000 | 16'(k / 2)};
      tests++;
      if (loads[k] !== exp) begin fails++; $display("FAIL stream_word[%0d]: got %h required %h", k, loads[k], exp); end
    end
    tests++; if (underrun_cnt !== 16'd0) begin fails++; $display("FAIL stream_cnt: got %0d required 0", underrun_cnt); end
    tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL stream_underrun: got %b required 0", underrun); end
    tests++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL stream_level: got %0d required 0", fifo_level); end
  endtask

  task automatic test_underrun();
    logic [31:0] fill;
    int n_real, n_fill, n_bad;
    do_reset();
    ctrl_en = 1'b1;
    push_frame(16'h1100, 16'h2200);
    push_frame(16'h1101, 16'h2201);
    push_frame(16'h0101, 16'h0202);
    fill = REPEAT_EN ? 32'h0101_0202 : {MUTE, MUTE};
    wait_loads(8, "und_first_fill");
    if (loads.size() >= 8) begin
      tests++; if (loads[6] !== {1'b1, fill[31:16]}) begin fails++; $display("FAIL und_fill_left: got %h required %h", loads[6], {1'b1, fill[31:16]}); end
      tests++; if (loads[7] !== {1'b0, fill[15:0]}) begin fails++; $display("FAIL und_fill_right: got %h required %h", loads[7], {1'b0, fill[15:0]}); end
    end
    tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL und_flag: got %b required 1", underrun); end
    tests++; if (underrun_cnt !== 16'd1) begin fails++; $display("FAIL und_cnt1: got %0d required 1", underrun_cnt); end
    wait_loads(10, "und_second_fill");
    tests++; if (underrun_cnt !== 16'd2) begin fails++; $display("FAIL und_cnt2: got %0d required 2", underrun_cnt); end
    push_frame(16'h3303, 16'h4403);
    push_frame(16'h3304, 16'h4404);
    wait_loads(14, "und_resume");
    if (loads.size() >= 14) begin
      tests++; if (loads[10] !== {1'b1, 16'h3303}) begin fails++; $display("FAIL und_resume_left: got %h required 13303", loads[10]); end
      tests++; if (loads[13] !== {1'b0, 16'h4404}) begin fails++; $display("FAIL und_resume_last: got %h required 04404", loads[13]); end
    end
    ctrl_en = 1'b0;
    wait_stop("und_stop");
    classify(n_real, n_fill, n_bad);
    tests++; if (n_bad != 0) begin fails++; $display("FAIL und_model_bad: got %0d bad frames required 0", n_bad); end
    tests++; if (n_real != 5) begin fails++; $display("FAIL und_model_real: got %0d required 5", n_real); end
    tests++; if (underrun_cnt !== 16'(n_fill)) begin fails++; $display("FAIL und_model_cnt: got %0d required %0d", underrun_cnt, n_fill); end
    tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL und_sticky: got %b required 1", underrun); end
    ctrl_en = 1'b1;
    repeat (3) @(negedge clk_in);
    tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL und_clear_on_rise: got %b required 0", underrun); end
    tests++; if (underrun_cnt !== 16'(n_fill)) begin fails++; $display("FAIL und_cnt_kept: got %0d required %0d", underrun_cnt, n_fill); end
    ctrl_en = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_full();
    logic [31:0] f;
    int n_real, n_fill, n_bad;
    do_reset();
    ser_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      f = rand_frame();
      push_frame(f[31:16], f[15:0]);
    end
    tests++; if (fifo_level !== 3'd4) begin fails++; $display("FAIL full_level: got %0d required 4", fifo_level); end
    tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL full_s_ready: got %b required 0", s_ready); end
    f = rand_frame();
    s_valid = 1'b1; s_left = f[31:16]; s_right = f[15:0];
    repeat (5) @(negedge clk_in);
    tests++; if (fifo_level !== 3'd4) begin fails++; $display("FAIL full_held_rejected: got %0d required 4", fifo_level); end
    ctrl_en = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    tests++; if (fifo_level !== 3'd3) begin fails++; $display("FAIL full_after_pop: got %0d required 3", fifo_level); end
    @(negedge clk_in);
    tests++; if (fifo_level !== 3'd4) begin fails++; $display("FAIL full_refill: got %0d required 4", fifo_level); end
    pushed.push_back(f);
    s_valid = 1'b0;
    ser_stall = 1'b0;
    wait_loads(10, "full_drain");
    ctrl_en = 1'b0;
    wait_stop("full_stop");
    classify(n_real, n_fill, n_bad);
    tests++; if (n_bad != 0 || n_fill != 0) begin fails++; $display("FAIL full_model: bad=%0d fill=%0d required 0/0", n_bad, n_fill); end
    tests++; if (n_real != 5) begin fails++; $display("FAIL full_model_real: got %0d required 5", n_real); end
    tests++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL full_final_level: got %0d required 0", fifo_level); end
  endtask

  task automatic test_random();
    logic [31:0] f;
    int n_real, n_fill, n_bad;
    do_reset();
    ctrl_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 30)) @(negedge clk_in);
      f = rand_frame();
      push_frame(f[31:16], f[15:0]);
    end
    repeat (100) @(negedge clk_in);
    ctrl_en = 1'b0;
    wait_stop("rand_stop");
    classify(n_real, n_fill, n_bad);
    tests++; if (n_bad != 0) begin fails++; $display("FAIL rand_model_bad: got %0d bad frames required 0", n_bad); end
    tests++; if (n_real != 24) begin fails++; $display("FAIL rand_model_real: got %0d required 24", n_real); end
    tests++; if (underrun_cnt !== 16'(n_fill)) begin fails++; $display("FAIL rand_cnt: got %0d required %0d", underrun_cnt, n_fill); end
    tests++; if (underrun !== (n_fill != 0)) begin fails++; $display("FAIL rand_flag: got %b required %b", underrun, n_fill != 0); end
    tests++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL rand_level: got %0d required 0", fifo_level); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] a, b;
    do_reset();
    ctrl_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a = rand_frame();
      push_frame(a[31:16], a[15:0]);
    end
    wait_loads(6, "rst_pre_underrun");
    for (int i = 0; i < 3; i++) begin
      a = rand_frame();
      push_frame(a[31:16], a[15:0]);
    end
    rstn = 1'b0;
    #1;
    tests++; if (tx_enable !== 1'b0) begin fails++; $display("FAIL rst_tx_enable: got %b required 0", tx_enable); end
    tests++; if (tx_data !== 16'h0) begin fails++; $display("FAIL rst_tx_data: got %h required 0000", tx_data); end
    tests++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL rst_level: got %0d required 0", fifo_level); end
    tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL rst_underrun: got %b required 0", underrun); end
    tests++; if (underrun_cnt !== 16'h0) begin fails++; $display("FAIL rst_cnt: got %0d required 0", underrun_cnt); end
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL rst_s_ready: got %b required 1", s_ready); end
    @(negedge clk_in);
    rstn = 1'b1;
    @(negedge clk_in);
    loads.delete();
    pushed.delete();
    a = rand_frame();
    push_frame(a[31:16], a[15:0]);
    repeat (6) @(negedge clk_in);
    tests++; if (tx_enable !== 1'b0) begin fails++; $display("FAIL rst_restart_wait: got %b required 0", tx_enable); end
    b = rand_frame();
    push_frame(b[31:16], b[15:0]);
    @(negedge clk_in);
    @(negedge clk_in);
    tests++; if (tx_enable !== 1'b1) begin fails++; $display("FAIL rst_restart_en: got %b required 1", tx_enable); end
    tests++; if (tx_data !== a[31:16]) begin fails++; $display("FAIL rst_restart_data: got %h required %h", tx_data, a[31:16]); end
    wait_loads(2, "rst_restart_loads");
    ctrl_en = 1'b0;
    wait_stop("rst_restart_stop");
    if (loads.size() >= 2) begin
      tests++; if (loads[0] !== {1'b1, a[31:16]}) begin fails++; $display("FAIL rst_restart_left: got %h required %h", loads[0], {1'b1, a[31:16]}); end
      tests++; if (loads[1] !== {1'b0, a[15:0]}) begin fails++; $display("FAIL rst_restart_right: got %h required %h", loads[1], {1'b0, a[15:0]}); end
    end
    tests++; if (fifo_level !== 3'd1) begin fails++; $display("FAIL rst_restart_level: got %0d required 1", fifo_level); end
  endtask

  initial begin
    rstn = 1'b0; ctrl_en = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;
    test_reset();
    test_prime_and_stop();
    test_stream();
    test_underrun();
    test_full();
    test_random();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
